range_tracker: RTL and testbench

RANGE_TRACKER -- requirements
Module: range_tracker

---
 rtl/range_tracker_if.sv | 27 ++
 rtl/range_tracker.sv | 133 +++++++++++++
 tb/tb_range_tracker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/range_tracker_if.sv
// Sample-stream and result bus for range_tracker. The master side drives the
// samples and framing; the slave side (the tracker) returns the statistics.
`timescale 1ns/1ps
interface range_tracker_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     data_in;
    logic                 go;
    logic                 finish;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     result;
    logic [CNT_WIDTH-1:0] count;
    logic                 valid;
    logic                 busy;
    logic                 error;

    modport master (
        output data_in, go, finish, mode,
        input  result, count, valid, busy, error
    );

    modport slave (
        input  data_in, go, finish, mode,
        output result, count, valid, busy, error
    );
endinterface

// File: rtl/range_tracker.sv
// Tracks min/max over a go..finish sample burst and reports range, min, max
// or midpoint plus the saturating sample count one cycle after finish.
`timescale 1ns/1ps
module range_tracker #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          SIGNED    = 1'b0
) (
    input logic             clock,
    input logic             reset_n,
    range_tracker_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     min_q, min_d, max_q, max_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;

    logic                 start, sample, complete, proto_err;
    logic [WIDTH-1:0]     new_min, new_max, range_val, mid_val;
    logic [WIDTH:0]       mid_sum;
    logic [CNT_WIDTH-1:0] cnt_inc;

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.go && !bus.finish) state_d = StRun;
            StRun:   if (bus.finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and control strobes
    always_comb begin
        bus.busy  = (state_q == StRun);
        start     = (state_q == StIdle) && bus.go && !bus.finish;
        sample    = (state_q == StRun);
        complete  = (state_q == StRun) && bus.finish;
        proto_err = ((state_q == StRun) && bus.go) || ((state_q == StIdle) && bus.finish);
    end

    // Statistics including the current cycle's sample
    always_comb begin
        new_min   = less_than(bus.data_in, min_q) ? bus.data_in : min_q;
        new_max   = less_than(max_q, bus.data_in) ? bus.data_in : max_q;
        cnt_inc   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        range_val = new_max - new_min;
        // One extra bit keeps the sum exact; dropping bit 0 floors the average.
        mid_sum   = {SIGNED & new_min[WIDTH-1], new_min} + {SIGNED & new_max[WIDTH-1], new_max};
        mid_val   = mid_sum[WIDTH:1];
    end

    always_comb begin
        min_d    = min_q;
        max_d    = max_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        count_d  = count_q;
        valid_d  = complete;
        error_d  = error_q;

        if (start) begin
            min_d   = bus.data_in;
            max_d   = bus.data_in;
            cnt_d   = CNT_WIDTH'(1);
            error_d = 1'b0;
        end else if (proto_err) begin
            error_d = 1'b1;
        end

        if (sample) begin
            min_d = new_min;
            max_d = new_max;
            cnt_d = cnt_inc;
        end

        if (complete) begin
            count_d = cnt_inc;
            unique case (bus.mode)
                2'd0:    result_d = range_val;
                2'd1:    result_d = new_min;
                2'd2:    result_d = new_max;
                default: result_d = mid_val;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_q    <= '0;
            max_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            min_q    <= min_d;
            max_q    <= max_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bus.result = result_q;
    assign bus.count  = count_q;
    assign bus.valid  = valid_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_range_tracker.sv
// Randomized and directed bench for range_tracker: three configurations
// (unsigned, signed, 4-bit counter) share one stimulus stream and one burst model.
`timescale 1ns/1ps
module tb_range_tracker;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in;
    logic       go, finish;
    logic [1:0] mode;

    range_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) bus0 ();
    range_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) bus1 ();
    range_tracker_if #(.WIDTH(8), .CNT_WIDTH(4)) bus2 ();

    assign bus0.data_in = data_in;
    assign bus0.go      = go;
    assign bus0.finish  = finish;
    assign bus0.mode    = mode;
    assign bus1.data_in = data_in;
    assign bus1.go      = go;
    assign bus1.finish  = finish;
    assign bus1.mode    = mode;
    assign bus2.data_in = data_in;
    assign bus2.go      = go;
    assign bus2.finish  = finish;
    assign bus2.mode    = mode;

    range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0));
    range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1));
    range_tracker #(.WIDTH(8), .CNT_WIDTH(4), .SIGNED(1'b0)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the burst is simply the list of samples seen so far.
    bit         m_busy, m_err, m_valid;
    logic [7:0] q[$];
    logic [7:0] m_res[3];
    int         m_cnt[3];
    bit         cfg_sgn[3] = '{1'b0, 1'b1, 1'b0};
    int         cfg_cw[3]  = '{8, 8, 4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sval(input bit s, input logic [7:0] x);
        return s ? int'($signed(x)) : int'(x);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_valid = 0;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            m_res[k] = 8'd0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_finish(input logic [1:0] m);
        for (int k = 0; k < 3; k++) begin
            int mn, mx, r, lim;
            mn = sval(cfg_sgn[k], q[0]);
            mx = mn;
            foreach (q[i]) begin
                if (sval(cfg_sgn[k], q[i]) < mn) mn = sval(cfg_sgn[k], q[i]);
                if (sval(cfg_sgn[k], q[i]) > mx) mx = sval(cfg_sgn[k], q[i]);
            end
            case (m)
                2'd0:    r = mx - mn;
                2'd1:    r = mn;
                2'd2:    r = mx;
                default: r = (mn + mx) >>> 1;
            endcase
            m_res[k] = r[7:0];
            lim = (1 << cfg_cw[k]) - 1;
            m_cnt[k] = (q.size() > lim) ? lim : q.size();
        end
    endtask

    task automatic model_step(input logic [7:0] d, input bit g, input bit f, input logic [1:0] m);
        if (!m_busy) begin
            m_valid = 0;
            if (g && !f) begin
                q.delete();
                q.push_back(d);
                m_busy = 1;
                m_err  = 0;
            end else if (f) begin
                m_err = 1;
            end
        end else begin
            q.push_back(d);
            if (g) m_err = 1;
            m_valid = f;
            if (f) begin
                model_finish(m);
                m_busy = 0;
            end
        end
    endtask

    task automatic check_dut(input string name, input int k, input logic [7:0] res,
                             input logic [7:0] cnt, input logic v, input logic b, input logic e);
        check({name, ".valid"},  32'(v),   32'(m_valid));
        check({name, ".busy"},   32'(b),   32'(m_busy));
        check({name, ".error"},  32'(e),   32'(m_err));
        check({name, ".result"}, 32'(res), 32'(m_res[k]));
        check({name, ".count"},  32'(cnt), 32'(m_cnt[k]));
    endtask

    task automatic check_all();
        check_dut("u8", 0, bus0.result, bus0.count, bus0.valid, bus0.busy, bus0.error);
        check_dut("s8", 1, bus1.result, bus1.count, bus1.valid, bus1.busy, bus1.error);
        check_dut("c4", 2, bus2.result, 8'(bus2.count), bus2.valid, bus2.busy, bus2.error);
    endtask

    task automatic step(input logic [7:0] d, input bit g, input bit f, input logic [1:0] m);
        data_in = d; go = g; finish = f; mode = m;
        @(posedge clock);
        model_step(d, g, f, m);
        #1;
        check_all();
    endtask

    initial begin
        data_in = 8'd0; go = 1'b0; finish = 1'b0; mode = 2'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Unsigned range 10,200,5,50
        step(8'd10, 1, 0, 2'd0);
        step(8'd200, 0, 0, 2'd0);
        step(8'd5, 0, 0, 2'd0);
        step(8'd50, 0, 1, 2'd0);
        check("dir_range_195", 32'(bus0.result), 32'd195);
        check("dir_count_4", 32'(bus0.count), 32'd4);
        check("dir_valid", 32'(bus0.valid), 32'd1);
        step(8'd0, 0, 0, 2'd0);
        check("dir_valid_drop", 32'(bus0.valid), 32'd0);

        // Signed extremes: range and midpoint
        step(8'h80, 1, 0, 2'd0);
        step(8'h7f, 0, 1, 2'd0);
        check("dir_srange_ff", 32'(bus1.result), 32'hff);
        check("dir_scount_2", 32'(bus1.count), 32'd2);
        step(8'h80, 1, 0, 2'd3);
        step(8'h7f, 0, 1, 2'd3);
        check("dir_smid_ff", 32'(bus1.result), 32'hff);

        // min then max on 7,3,9
        step(8'd7, 1, 0, 2'd0);
        step(8'd3, 0, 0, 2'd0);
        step(8'd9, 0, 1, 2'd1);
        check("dir_min_3", 32'(bus0.result), 32'd3);
        step(8'd7, 1, 0, 2'd0);
        step(8'd3, 0, 0, 2'd0);
        step(8'd9, 0, 1, 2'd2);
        check("dir_max_9", 32'(bus0.result), 32'd9);

        // 20-sample burst saturates the 4-bit counter
        for (int i = 0; i < 20; i++) step(8'(i * 11), i == 0, i == 19, 2'd0);
        check("dir_sat_15", 32'(bus2.count), 32'd15);
        check("dir_nosat_20", 32'(bus0.count), 32'd20);

        // Protocol errors
        step(8'd1, 1, 1, 2'd0);
        check("dir_gofin_err", 32'(bus0.error), 32'd1);
        check("dir_gofin_busy", 32'(bus0.busy), 32'd0);
        step(8'd4, 1, 0, 2'd0);
        check("dir_err_clear", 32'(bus0.error), 32'd0);
        step(8'd8, 1, 0, 2'd0);
        step(8'd2, 1, 1, 2'd0);
        check("dir_run_gofin_err", 32'(bus0.error), 32'd1);
        check("dir_run_gofin_res", 32'(bus0.result), 32'd6);
        step(8'd0, 0, 1, 2'd0);

        // Half-cycle reset mid-burst
        step(8'd1, 1, 0, 2'd0);
        step(8'd2, 0, 0, 2'd0);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #4;
        reset_n = 1'b1;
        step(8'd4, 1, 0, 2'd0);
        step(8'd6, 0, 1, 2'd0);
        check("dir_post_rst_range", 32'(bus0.result), 32'd2);
        check("dir_post_rst_count", 32'(bus0.count), 32'd2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            logic [1:0] m;
            bit g, f;
            d = 8'($urandom);
            m = 2'($urandom);
            g = ($urandom_range(0, 6) == 0);
            f = ($urandom_range(0, 5) == 0);
            step(d, g, f, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
